usb_rx_pkt_decoder: RTL

USB_RX_PKT_DECODER -- requirements
Module: usb_rx_pkt_decoder

---
 rtl/usb_rx_pkt_decoder_if.sv | 28 ++
 rtl/usb_rx_pkt_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_pkt_decoder_if.sv
// Bundles the PHY receive signals and the decoded host-side signals of the USB RX packet decoder.
// The PHY/bench side uses the master modport and the decoder uses the slave modport.
interface usb_rx_pkt_decoder_if;
    logic        rx_active;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_error;
    logic        host_pkt_valid;
    logic [3:0]  host_pid;
    logic [6:0]  host_addr;
    logic [3:0]  host_ep;
    logic [7:0]  host_data;
    logic        host_data_valid;
    logic [15:0] host_data_len;
    logic        host_crc_err;

    modport master (
        output rx_active, rx_valid, rx_data, rx_error,
        input  host_pkt_valid, host_pid, host_addr, host_ep,
               host_data, host_data_valid, host_data_len, host_crc_err
    );

    modport slave (
        input  rx_active, rx_valid, rx_data, rx_error,
        output host_pkt_valid, host_pid, host_addr, host_ep,
               host_data, host_data_valid, host_data_len, host_crc_err
    );
endinterface

// File: rtl/usb_rx_pkt_decoder.sv
// USB receive packet decoder: checks the PID, decodes token/data/handshake packets,
// verifies CRC5/CRC16 and streams data payload through a two-byte holding pipeline.
module usb_rx_pkt_decoder #(
    parameter int MAX_PAYLOAD = 64
) (
    input logic                 clk,
    input logic                 rst,
    usb_rx_pkt_decoder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PID, TOKEN, DATA, HSK, DROP, DONE} state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    state_t      state_q;
    logic [3:0]  pid_q;
    logic [1:0]  cnt_q;
    logic [7:0]  h0_q;
    logic [7:0]  h1_q;
    logic [15:0] crc16_q;
    logic [15:0] pay_cnt_q;
    logic        ovf_q;
    logic        err_q;
    logic        pkt_valid_q;
    logic [3:0]  host_pid_q;
    logic [6:0]  host_addr_q;
    logic [3:0]  host_ep_q;
    logic [7:0]  host_data_q;
    logic        data_valid_q;
    logic [15:0] host_len_q;
    logic        host_err_q;

    logic        pid_ok;

    function automatic state_t pid_class(input logic [3:0] p);
        case (p)
            4'h1, 4'h9, 4'hD, 4'h5: return TOKEN;
            4'h3, 4'hB:             return DATA;
            default:                return HSK;
        endcase
    endfunction

    // The received CRC5 field arrives MSB first, so it is the bit-reversed complement.
    function automatic logic crc5_match(input logic [7:0] b1, input logic [7:0] b2);
        logic [4:0]  crc;
        logic [10:0] bits;
        bits = {b2[2:0], b1};
        crc  = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (crc[4] ^ bits[i]) crc = {crc[3:0], 1'b0} ^ 5'h05;
            else                  crc = {crc[3:0], 1'b0};
        end
        return b2[7:3] == {~crc[0], ~crc[1], ~crc[2], ~crc[3], ~crc[4]};
    endfunction

    // Reflected register form, so the complement lines up directly with {high, low}.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] b);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign pid_ok = (bus.rx_data[7:4] == ~bus.rx_data[3:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pid_q        <= 4'h0;
            cnt_q        <= 2'd0;
            h0_q         <= 8'h00;
            h1_q         <= 8'h00;
            crc16_q      <= 16'hFFFF;
            pay_cnt_q    <= 16'h0000;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            pkt_valid_q  <= 1'b0;
            host_pid_q   <= 4'h0;
            host_addr_q  <= 7'h00;
            host_ep_q    <= 4'h0;
            host_data_q  <= 8'h00;
            data_valid_q <= 1'b0;
            host_len_q   <= 16'h0000;
            host_err_q   <= 1'b0;
        end else begin
            pkt_valid_q  <= 1'b0;
            data_valid_q <= 1'b0;
            case (state_q)
                IDLE, PID: begin
                    if (bus.rx_active) begin
                        err_q <= (state_q == PID) ? (err_q | bus.rx_error) : bus.rx_error;
                        if (bus.rx_valid) begin
                            cnt_q     <= 2'd0;
                            crc16_q   <= 16'hFFFF;
                            pay_cnt_q <= 16'h0000;
                            ovf_q     <= 1'b0;
                            if (pid_ok) begin
                                pid_q   <= bus.rx_data[3:0];
                                state_q <= pid_class(bus.rx_data[3:0]);
                            end else begin
                                state_q <= DROP;
                            end
                        end else begin
                            state_q <= PID;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                TOKEN, DATA, HSK: begin
                    if (!bus.rx_active) begin
                        state_q     <= DONE;
                        pkt_valid_q <= 1'b1;
                        host_pid_q  <= pid_q;
                        case (state_q)
                            TOKEN: begin
                                host_addr_q <= h0_q[6:0];
                                host_ep_q   <= {h1_q[2:0], h0_q[7]};
                                host_len_q  <= 16'h0000;
                                host_err_q  <= err_q || (cnt_q != 2'd2) || !crc5_match(h0_q, h1_q);
                            end
                            DATA: begin
                                host_addr_q <= 7'h00;
                                host_ep_q   <= 4'h0;
                                host_len_q  <= pay_cnt_q;
                                host_err_q  <= err_q || ovf_q || (cnt_q < 2'd2) ||
                                               ({h1_q, h0_q} != ~crc16_q);
                            end
                            default: begin
                                host_addr_q <= 7'h00;
                                host_ep_q   <= 4'h0;
                                host_len_q  <= 16'h0000;
                                host_err_q  <= err_q || (cnt_q != 2'd0);
                            end
                        endcase
                    end else begin
                        err_q <= err_q | bus.rx_error;
                        if (bus.rx_valid) begin
                            if (cnt_q != 2'd3) cnt_q <= cnt_q + 2'd1;
                            if (cnt_q == 2'd0) begin
                                h0_q <= bus.rx_data;
                            end else if (cnt_q == 2'd1) begin
                                h1_q <= bus.rx_data;
                            end else if (state_q == DATA) begin
                                // Pipeline full: the oldest held byte is payload, never CRC.
                                h0_q    <= h1_q;
                                h1_q    <= bus.rx_data;
                                crc16_q <= crc16_byte(crc16_q, h0_q);
                                if (pay_cnt_q < MAX_LEN) begin
                                    host_data_q  <= h0_q;
                                    data_valid_q <= 1'b1;
                                    pay_cnt_q    <= pay_cnt_q + 16'd1;
                                end else begin
                                    ovf_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                DROP: begin
                    if (!bus.rx_active) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.host_pkt_valid  = pkt_valid_q;
    assign bus.host_pid        = host_pid_q;
    assign bus.host_addr       = host_addr_q;
    assign bus.host_ep         = host_ep_q;
    assign bus.host_data       = host_data_q;
    assign bus.host_data_valid = data_valid_q;
    assign bus.host_data_len   = host_len_q;
    assign bus.host_crc_err    = host_err_q;
endmodule
